// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: state encoding, default
// parameters and the counter-width function.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_GAP      = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int DEF_NUM_DOMAINS    = 4;
  localparam int DEF_HOLD_CYCLES    = 8;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating up-counter with a terminal-count compare, reused for the
// hold, gap and ready-timeout phases of the sequencer.
module rst_seq_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases them in index order
// with a fixed gap. Define RST_SEQ_RDY_WAIT_EN to wait on per-domain ready.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
`ifdef RST_SEQ_RDY_WAIT_EN
  input  logic [NUM_DOMAINS-1:0] DOMAIN_RDY,
  output logic                   TIMEOUT_ERR,
`endif
  output logic                   SW_RST_ACK,
  output logic [NUM_DOMAINS-1:0] RST_OUT,
  output logic                   BUSY,
  output logic                   SEQ_DONE
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);
  localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC   = CW'(GAP_CYCLES - 1);
`ifdef RST_SEQ_RDY_WAIT_EN
  localparam logic [CW-1:0] TO_TC    = CW'(TIMEOUT_CYCLES - 1);
  logic terr_q, terr_d, rdy_cur;
`endif

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d, rel_idx;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   busy_q, busy_d, done_q, done_d, ack_q, ack_d;
  logic                   tmr_clr, tmr_en, tmr_tc;
  logic [CW-1:0]          tmr_term;

  rst_seq_timer #(.CW(CW)) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .term (tmr_term),
    .tc   (tmr_tc)
  );

  always_comb begin
    tmr_term = '0;
    case (state_q)
      ST_ASSERT:   tmr_term = HOLD_TC;
      ST_GAP:      tmr_term = GAP_TC;
`ifdef RST_SEQ_RDY_WAIT_EN
      ST_WAIT_RDY: tmr_term = TO_TC;
`endif
      default:     tmr_term = '0;
    endcase
  end

`ifdef RST_SEQ_RDY_WAIT_EN
  always_comb begin
    rdy_cur = 1'b0;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (IW'(i) == idx_q) rdy_cur = DOMAIN_RDY[i];
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ack_d     = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b1;
    rel_idx   = (state_q == ST_GAP) ? idx_q : '0;
`ifdef RST_SEQ_RDY_WAIT_EN
    terr_d    = terr_q;
`endif
    case (state_q)
      ST_ASSERT, ST_GAP: begin
        if (tmr_tc) begin
          for (int i = 0; i < NUM_DOMAINS; i++)
            if (IW'(i) == rel_idx) rst_out_d[i] = 1'b1;
          tmr_clr = 1'b1;
          idx_d   = rel_idx;
`ifdef RST_SEQ_RDY_WAIT_EN
          state_d = ST_WAIT_RDY;
`else
          if (rel_idx == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            idx_d   = rel_idx + IW'(1);
          end
`endif
        end
      end
`ifdef RST_SEQ_RDY_WAIT_EN
      ST_WAIT_RDY: begin
        // A timeout is flagged but otherwise treated like a ready indication.
        if (rdy_cur || tmr_tc) begin
          if (!rdy_cur) terr_d = 1'b1;
          tmr_clr = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
`endif
      ST_DONE: begin
        // The first DONE cycle already samples the request, so a request held
        // during the sequence is accepted before SEQ_DONE is ever shown.
        tmr_en = 1'b0;
        if (SW_RST_REQ) begin
          state_d   = ST_ASSERT;
          idx_d     = '0;
          rst_out_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          ack_d     = 1'b1;
          tmr_clr   = 1'b1;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_ASSERT;
      idx_q     <= '0;
      rst_out_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
    end
  end

`ifdef RST_SEQ_RDY_WAIT_EN
  always_ff @(posedge CLK) begin
    if (RST) terr_q <= 1'b0;
    else     terr_q <= terr_d;
  end
  assign TIMEOUT_ERR = terr_q;
`endif

  assign RST_OUT    = rst_out_q;
  assign BUSY       = busy_q;
  assign SEQ_DONE   = done_q;
  assign SW_RST_ACK = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: table of per-edge vectors checked through a
// scoreboard queue, plus a short sequence on a single-domain instance.
module tb_rst_seq_ctrl;

  typedef struct {
    logic       rst;
    logic       req;
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic       ack;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST, SW_RST_REQ, SW_RST_ACK, BUSY, SEQ_DONE;
  logic [3:0] RST_OUT;
  logic       rst1, req1, ack1, busy1, done1;
  logic [0:0] out1;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_vec  = 0;

  always #5 CLK = ~CLK;

  rst_seq_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .SW_RST_ACK (SW_RST_ACK),
    .RST_OUT    (RST_OUT),
    .BUSY       (BUSY),
    .SEQ_DONE   (SEQ_DONE)
  );

  rst_seq_ctrl #(.NUM_DOMAINS(1), .HOLD_CYCLES(2)) dut1 (
    .CLK        (CLK),
    .RST        (rst1),
    .SW_RST_REQ (req1),
    .SW_RST_ACK (ack1),
    .RST_OUT    (out1),
    .BUSY       (busy1),
    .SEQ_DONE   (done1)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Expected domain outputs k edges after reset/ack: bit i high from edge 8+4i.
  function automatic logic [3:0] exp_out(input int k);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (k >= 8 + 4 * i) r[i] = 1'b1;
    return r;
  endfunction

  task automatic add(input logic rst, input logic req, input logic [3:0] out,
                     input logic busy, input logic done, input logic ack);
    vec_t v;
    v.rst = rst; v.req = req; v.out = out;
    v.busy = busy; v.done = done; v.ack = ack;
    tbl.push_back(v);
  endtask

  task automatic add_run(input int k0, input int k1, input logic req);
    for (int k = k0; k <= k1; k++)
      add(1'b0, req, exp_out(k), !(k >= 21), (k >= 21), 1'b0);
  endtask

  always @(negedge CLK) begin
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rst_out", n_vec, 32'(RST_OUT),    32'(e.out));
      chk("busy",    n_vec, 32'(BUSY),       32'(e.busy));
      chk("done",    n_vec, 32'(SEQ_DONE),   32'(e.done));
      chk("ack",     n_vec, 32'(SW_RST_ACK), 32'(e.ack));
      n_vec++;
    end
  end

  initial begin
    RST = 1'b1; SW_RST_REQ = 1'b0;
    rst1 = 1'b1; req1 = 1'b0;

    // Single domain, hold of 2: release at edge 2, done at edge 3.
    @(posedge CLK); #1;
    chk("d1_rst_out", 0, 32'(out1),  32'd0);
    chk("d1_busy",    0, 32'(busy1), 32'd1);
    chk("d1_done",    0, 32'(done1), 32'd0);
    @(negedge CLK); rst1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      chk("d1_rst_out", k, 32'(out1),  32'(k >= 2));
      chk("d1_done",    k, 32'(done1), 32'(k >= 3));
      chk("d1_busy",    k, 32'(busy1), 32'(k < 3));
      chk("d1_ack",     k, 32'(ack1),  32'd0);
    end

    repeat (3) add(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    add_run(1, 22, 1'b0);
    add(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);      // request in DONE
    add_run(1, 3, 1'b1);                             // still high: no re-ack
    add_run(4, 9, 1'b0);
    add_run(10, 20, 1'b1);                           // early request held
    add(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);      // accepted at edge 21
    add_run(1, 22, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);      // RST beats request
    add_run(1, 13, 1'b0);
    add(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);      // mid-sequence reset
    add_run(1, 22, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK); #1;
      RST        = tbl[i].rst;
      SW_RST_REQ = tbl[i].req;
      sb.push_back(tbl[i]);
    end
    @(negedge CLK); #2;
    chk("sb_drained", 0, 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer that sits downstream of the reset synchronizer in the CLK domain.
- Holds NUM_DOMAINS active-low domain resets asserted for a minimum hold time, then releases them one at a time in index order with a fixed gap between releases.
- Provides a level request / single-cycle acknowledge handshake for a software-initiated re-sequence.
- Drives the resets of the register file, FIFO, UART and ALU domains in the system.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset outputs; must be >= 1.
- HOLD_CYCLES, 8, cycles all outputs stay asserted after reset or a software request; must be >= 1.
- GAP_CYCLES, 4, cycles between consecutive domain releases; must be >= 1.
- TIMEOUT_CYCLES, 255, maximum wait per domain for the ready signal; used only with RST_SEQ_RDY_WAIT_EN.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset, synchronous to CLK, active-high.
- SW_RST_REQ  in  1  software re-sequence request; level, held high until acknowledged.
- SW_RST_ACK  out  1  one-cycle pulse when the request is accepted.
- RST_OUT  out  NUM_DOMAINS  per-domain reset, active-low; bit 0 is released first.
- BUSY  out  1  high while the sequence is in progress.
- SEQ_DONE  out  1  high when all domains are released.

Behaviour:
- All outputs are registered.
- Reset (RST=1 at a CLK edge):
  - state=ASSERT, counter=0, domain index=0.
  - RST_OUT=all 0, BUSY=1, SEQ_DONE=0, SW_RST_ACK=0.
  - RST is honoured in every state, including mid-sequence: released domains are re-asserted at that edge.
- Edge numbering: edge 1 is the first rising edge at which RST is sampled 0.
- State ASSERT:
  - Count HOLD_CYCLES edges.
  - At edge HOLD_CYCLES, set RST_OUT[0]=1.
  - If NUM_DOMAINS=1, go to DONE; otherwise go to GAP with index=1.
- State GAP:
  - Count GAP_CYCLES edges, then set RST_OUT[index]=1.
  - If index=NUM_DOMAINS-1, go to DONE; otherwise increment index.
  - Release edges: RST_OUT[i] rises at edge HOLD_CYCLES + i*GAP_CYCLES.
- State DONE:
  - Entered one edge after the last release; SEQ_DONE=1, BUSY=0 from that edge.
  - Example (defaults): releases at edges 8, 12, 16, 20; SEQ_DONE rises at edge 21.
- Software request:
  - SW_RST_REQ sampled 1 while in DONE: at that edge go to ASSERT, RST_OUT=all 0, BUSY=1, SEQ_DONE=0, SW_RST_ACK=1 for exactly one cycle, counter=0.
  - Hold counting then restarts exactly as after RST.
  - SW_RST_REQ while BUSY=1 is not acknowledged and not lost; it is accepted on the first DONE cycle if still high.
  - If SW_RST_REQ is still high after the ack, it is treated as a new request only after the next DONE.
  - RST=1 and SW_RST_REQ=1 at the same edge: RST wins and no ack is issued.
- Invariants:
  - Each released bit stays 1 until the next RST or accepted request.
  - RST_OUT is monotone: bit i is never high while bit j<i is low.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1); counters saturate and never wrap.

Optional Feature:
- Macro: RST_SEQ_RDY_WAIT_EN.
- When defined:
  - Adds port DOMAIN_RDY in NUM_DOMAINS, per-domain "out of reset" indication.
  - Adds port TIMEOUT_ERR out 1, sticky, cleared only by RST.
  - After releasing domain i, a WAIT_RDY state waits for DOMAIN_RDY[i]=1 before the GAP count for domain i+1 begins.
  - If not ready within TIMEOUT_CYCLES edges, set TIMEOUT_ERR=1 and proceed as if ready.
  - After the last domain is released, DONE is entered only once DOMAIN_RDY[NUM_DOMAINS-1]=1 or its timeout expires.
- When not defined: no extra ports, purely timed sequence, no WAIT_RDY state.

Decomposition:
- Package rst_seq_pkg:
  - State encoding: ASSERT, GAP, WAIT_RDY, DONE.
  - Counter-width function.
  - Default parameter constants.
- Sub-module rst_seq_timer: loadable saturating counter with a terminal-count flag, shared by the hold, gap and timeout phases.
- FSM and output registers live in rst_seq_ctrl.

Test Plan:
- Power-up, defaults: RST=1 for 3 cycles, then 0 -> RST_OUT=0000 during reset; bits rise at edges 8, 12, 16, 20 (0001, 0011, 0111, 1111); SEQ_DONE=1 and BUSY=0 at edge 21.
- Mid-sequence reset: RST=1 at edge 14 (RST_OUT=0011) -> 0000 at that edge; after RST deasserts, full sequence restarts from edge 1.
- Software request in DONE: SW_RST_REQ held high -> SW_RST_ACK for exactly 1 cycle, RST_OUT=0000 same edge, sequence repeats with the same 8/4 timing.
- Early request: SW_RST_REQ asserted at edge 10 and held -> no ack until DONE at edge 21; ack at edge 21 (accepted on the first DONE cycle); second sequence follows.
- NUM_DOMAINS=1, HOLD_CYCLES=2 -> RST_OUT rises at edge 2, SEQ_DONE at edge 3.
- With RST_SEQ_RDY_WAIT_EN, TIMEOUT_CYCLES=10, DOMAIN_RDY[1] tied 0 -> TIMEOUT_ERR=1 ten edges after RST_OUT[1] rises; bits 2 and 3 still released; SEQ_DONE reached.
